flash_spi_reader: RTL and testbench
===================================

Name: flash_spi_reader

Overview:
- SPI master between the STM32 parallel-bus interface and the FPGA configuration flash.
- The bus interface delivers one command byte plus an enable level. It then polls `FLASH_busy` and pulses `FLASH_continue_read` to stream bytes back to the STM32.
- This block runs the flash transaction: opcode, optional auto-generated 24-bit address, then byte-wise reads. Each new byte is exposed on `data_out` with a busy/continue handshake.

Parameters:
- CLK_DIV, 2, SCK half-period in `clk_in` cycles (≥1). SCK frequency = f(clk_in) / (2·CLK_DIV).
- READ_OPCODE, 8'h03, opcode that triggers automatic address insertion.
- START_ADDR, 24'h000000, address sent after READ_OPCODE.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- cmd_in  in  8  opcode byte; driven from the interface's `FLASH_data_out`
- enable  in  1  session level; high = session active; driven from `FLASH_enable`
- continue_read  in  1  single-cycle request for the next byte; driven from `FLASH_continue_read`
- data_out  out  8  last byte received from flash; drives the interface's `FLASH_data_in`
- busy  out  1  high while a transfer is in progress; drives `FLASH_busy`
- flash_cs_n  out  1  flash chip select, active low
- flash_sck  out  1  SPI clock, mode 0
- flash_mosi  out  1  SPI data to flash
- flash_miso  in  1  SPI data from flash

Behaviour:
- One clock domain, `clk_in`. Reset is asynchronous and active-high.
- Reset values: `data_out`=8'hFF, `busy`=0, `flash_cs_n`=1, `flash_sck`=0, `flash_mosi`=0, state=IDLE.
- SPI mode 0:
  - SCK idles low.
  - MOSI is updated on the `clk_in` edge that drives SCK low (or at byte start), MSB first.
  - MISO is sampled on the `clk_in` edge that drives SCK high.
- States: IDLE, CMD, ADDR, XFER, READY.
- IDLE, on detecting `enable` rising (registered previous value):
  - latch `cmd_in`; set `data_out`=8'hFF;
  - `busy`=1 and `flash_cs_n`=0 on the same edge;
  - go to CMD.
- CMD: shift 8 bits of the latched opcode.
  - If opcode == READ_OPCODE → ADDR.
  - Otherwise → XFER (status/ID style opcodes read back immediately).
- ADDR: shift START_ADDR, 24 bits, MSB first → XFER.
- XFER:
  - shift out 8'h00 while capturing 8 MISO bits;
  - after the 8th rising SCK and the following SCK-low half-period: `data_out` ← captured byte, `busy`=0 on the same edge → READY.
  - `flash_cs_n` stays low.
- READY:
  - `continue_read`=1 sampled → `busy`=1 on that same edge, → XFER. The next byte is fetched from the auto-incrementing flash stream.
  - Latency to `busy` high: 0 cycles after the sampling edge. The interface re-samples busy 2 cycles after asserting `continue_read` and must see 1.
- `continue_read` seen in any state other than READY is ignored. This includes the first pulse the interface issues before `busy` is visible. No queuing.
- `data_out` changes only at XFER completion or session start. It is stable while `busy`=1 apart from the start-of-session 8'hFF.
- `enable` low in any state:
  - next edge: `flash_cs_n`=1, `flash_sck`=0, `flash_mosi`=0, `busy`=0, state=IDLE;
  - `data_out` keeps its last value;
  - a partial byte is discarded.
- `enable` low then high again: a new session starting from CMD with a freshly latched `cmd_in`. The address restarts at START_ADDR; there is no address persistence.
- `enable` held high continuously does not retrigger a session.
- `reset_in` mid-transfer: all outputs return to reset values immediately (asynchronous).
- SCK divider counter: counts 0..CLK_DIV-1 and toggles SCK on wrap. It is cleared whenever state is IDLE.
- Bit counter widths:
  - 3 bits for 8-bit fields;
  - 5 bits for the 24-bit address;
  - bit-count wrap to 0 marks the end of a field.
- CS timing:
  - CS falls at least one half-period before the first SCK rise.
  - CS stays low from CMD until the session ends, so the flash's sequential read continues across bytes.

Test Plan:
- Reset (`reset_in`=1 then 0) → `data_out`=8'hFF, `busy`=0, `flash_cs_n`=1, `flash_sck`=0; no SCK edges while `enable`=0.
- READ session: `cmd_in`=8'h03, `enable`↑, flash model returns A5, 3C →
  - MOSI carries 03 00 00 00 then 00;
  - exactly 40 SCK rises before `busy` falls with `data_out`=8'hA5;
  - a `continue_read` pulse → `busy` high on the sampling edge, then `data_out`=8'h3C after 8 more SCK rises.
- JEDEC ID session: `cmd_in`=8'h9F, MISO=EF → no address phase; `busy` falls after 16 SCK rises with `data_out`=8'hEF.
- Handshake: `continue_read` pulsed while `busy`=1, and a pulse one cycle after `enable`↑ → ignored, byte count unchanged. Interface-style 2-cycle polling loop → every byte delivered once with none skipped.
- Abort: drop `enable` at bit 4 of ADDR → next edge `flash_cs_n`=1, `busy`=0, `flash_sck`=0. Re-enable with 8'h03 → address restarts at 000000.
- Async reset asserted mid-XFER between clock edges → outputs reach reset values before the next `clk_in` edge. CLK_DIV=1 and CLK_DIV=4 both pass the READ session.

Source files
------------

// File: rtl/flash_spi_reader.sv
// SPI mode-0 master that reads the FPGA configuration flash for the STM32 bus interface.
// Sends an opcode, an optional start address, then streams one byte per continue_read request.
module flash_spi_reader #(
   parameter int          CLK_DIV     = 2,
   parameter logic [7:0]  READ_OPCODE = 8'h03,
   parameter logic [23:0] START_ADDR  = 24'h000000
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic [7:0] cmd_in,
   input  logic       enable,
   input  logic       continue_read,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       flash_cs_n,
   output logic       flash_sck,
   output logic       flash_mosi,
   input  logic       flash_miso
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, XFER, READY} state_t;

   state_t           state;
   logic             enable_q;
   logic [7:0]       opcode;
   logic [22:0]      tx;
   logic [7:0]       rx;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       byte_bit;
   logic [4:0]       addr_bit;
   logic             tail;
   logic             div_wrap;

   assign div_wrap = (div_cnt == DIV_LAST);

   // tx holds the bits still to be sent after the one currently on flash_mosi.
   // tail marks the final SCK-low half-period of a received byte before it is published.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state      <= IDLE;
         enable_q   <= 1'b0;
         opcode     <= '0;
         tx         <= '0;
         rx         <= '0;
         div_cnt    <= '0;
         byte_bit   <= '0;
         addr_bit   <= '0;
         tail       <= 1'b0;
         data_out   <= 8'hFF;
         busy       <= 1'b0;
         flash_cs_n <= 1'b1;
         flash_sck  <= 1'b0;
         flash_mosi <= 1'b0;
      end else begin
         enable_q <= enable;
         if (!enable) begin
            state      <= IDLE;
            div_cnt    <= '0;
            byte_bit   <= '0;
            addr_bit   <= '0;
            tail       <= 1'b0;
            busy       <= 1'b0;
            flash_cs_n <= 1'b1;
            flash_sck  <= 1'b0;
            flash_mosi <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  div_cnt <= '0;
                  if (!enable_q) begin
                     opcode     <= cmd_in;
                     data_out   <= 8'hFF;
                     busy       <= 1'b1;
                     flash_cs_n <= 1'b0;
                     flash_sck  <= 1'b0;
                     flash_mosi <= cmd_in[7];
                     tx         <= {cmd_in[6:0], 16'h0000};
                     byte_bit   <= '0;
                     addr_bit   <= '0;
                     tail       <= 1'b0;
                     state      <= CMD;
                  end
               end
               READY: begin
                  if (continue_read) begin
                     busy       <= 1'b1;
                     flash_mosi <= 1'b0;
                     tx         <= '0;
                     byte_bit   <= '0;
                     tail       <= 1'b0;
                     state      <= XFER;
                  end
               end
               default: begin
                  div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                  if (div_wrap) begin
                     if (tail) begin
                        data_out <= rx;
                        busy     <= 1'b0;
                        tail     <= 1'b0;
                        state    <= READY;
                     end else if (!flash_sck) begin
                        flash_sck <= 1'b1;
                        rx        <= {rx[6:0], flash_miso};
                     end else begin
                        flash_sck <= 1'b0;
                        case (state)
                           CMD: begin
                              byte_bit <= byte_bit + 3'd1;
                              if (byte_bit == 3'd7) begin
                                 if (opcode == READ_OPCODE) begin
                                    state      <= ADDR;
                                    addr_bit   <= '0;
                                    flash_mosi <= START_ADDR[23];
                                    tx         <= START_ADDR[22:0];
                                 end else begin
                                    state      <= XFER;
                                    flash_mosi <= 1'b0;
                                    tx         <= '0;
                                 end
                              end else begin
                                 flash_mosi <= tx[22];
                                 tx         <= {tx[21:0], 1'b0};
                              end
                           end
                           ADDR: begin
                              if (addr_bit == 5'd23) begin
                                 addr_bit   <= '0;
                                 byte_bit   <= '0;
                                 state      <= XFER;
                                 flash_mosi <= 1'b0;
                                 tx         <= '0;
                              end else begin
                                 addr_bit   <= addr_bit + 5'd1;
                                 flash_mosi <= tx[22];
                                 tx         <= {tx[21:0], 1'b0};
                              end
                           end
                           default: begin
                              byte_bit   <= byte_bit + 3'd1;
                              flash_mosi <= 1'b0;
                              if (byte_bit == 3'd7) begin
                                 tail <= 1'b1;
                              end
                           end
                        endcase
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Bench for flash_spi_reader: three instances (CLK_DIV 2, 1, 4) each talk to a behavioural flash
// model; a per-cycle scoreboard checks the session/handshake rules and every delivered byte.
module tb_flash_spi_reader;

   localparam int         NDUT    = 3;
   localparam logic [7:0] READ_OP = 8'h03;

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic [7:0] cmd_in;
   logic       enable        [NDUT];
   logic       continue_read [NDUT];
   logic [7:0] data_out      [NDUT];
   logic       busy          [NDUT];
   logic       flash_cs_n    [NDUT];
   logic       flash_sck     [NDUT];
   logic       flash_mosi    [NDUT];
   logic       flash_miso    [NDUT];

   always #5 clk_in = ~clk_in;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      flash_spi_reader #(
         .CLK_DIV    ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
         .READ_OPCODE(8'h03),
         .START_ADDR (24'h000000)
      ) dut (
         .clk_in       (clk_in),
         .reset_in     (reset_in),
         .cmd_in       (cmd_in),
         .enable       (enable[g]),
         .continue_read(continue_read[g]),
         .data_out     (data_out[g]),
         .busy         (busy[g]),
         .flash_cs_n   (flash_cs_n[g]),
         .flash_sck    (flash_sck[g]),
         .flash_mosi   (flash_mosi[g]),
         .flash_miso   (flash_miso[g])
      );
   end

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] mem [256];

   // flash model state, indexed by instance
   int          rises      [NDUT];
   logic        sck_prev   [NDUT];
   logic [31:0] mosi_sr    [NDUT];
   logic [7:0]  seen_opc   [NDUT];
   logic [23:0] seen_addr  [NDUT];
   // session/handshake reference state
   logic        sess       [NDUT];
   logic        en_last    [NDUT];
   logic        en_prev    [NDUT];
   logic        cr_last    [NDUT];
   logic [7:0]  cmd_last   [NDUT];
   logic        prev_busy  [NDUT];
   logic [7:0]  prev_data  [NDUT];
   logic [7:0]  sess_cmd   [NDUT];
   int          delivered  [NDUT];
   int          fall_rises [NDUT];

   // Byte j of the flash's sequential output for a given opcode and start address.
   function automatic logic [7:0] ref_byte(input logic [7:0] opc, input logic [23:0] addr, input int j);
      logic [7:0] a;
      if (opc == READ_OP) begin
         a = addr[7:0] + 8'(j);
         return mem[a];
      end else if (opc == 8'h9F) begin
         case (j % 3)
            0:       return 8'hEF;
            1:       return 8'h40;
            default: return 8'h18;
         endcase
      end
      return 8'h5A ^ 8'(j);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Flash model and per-cycle scoreboard, sampled on the falling clk_in edge.
   always @(negedge clk_in) begin : model
      logic       start, sess_new, ready_was, exp_rise, allowed;
      int         hdr, j, b;
      logic [7:0] byt;
      for (int i = 0; i < NDUT; i++) begin
         if (reset_in) begin
            sess[i] = 1'b0; en_prev[i] = 1'b0; en_last[i] = enable[i]; cr_last[i] = 1'b0;
            prev_busy[i] = 1'b0; prev_data[i] = 8'hFF; sck_prev[i] = 1'b0; rises[i] = 0;
            seen_opc[i] = 8'h00; seen_addr[i] = 24'h0; flash_miso[i] = 1'b0; cmd_last[i] = cmd_in;
         end else begin
            start     = en_last[i] && !sess[i] && !en_prev[i];
            sess_new  = en_last[i] && (sess[i] || !en_prev[i]);
            ready_was = sess[i] && !prev_busy[i];
            exp_rise  = start || (sess_new && ready_was && cr_last[i]);
            if (start) begin
               sess_cmd[i]  = cmd_last[i];
               delivered[i] = 0;
               checkOutput("start_data_ff", data_out[i], 8'hFF);
            end

            // flash side: observe SCK rises, capture MOSI, drive MISO
            if (flash_cs_n[i]) begin
               rises[i] = 0; seen_opc[i] = 8'h00; seen_addr[i] = 24'h0;
            end else if (flash_sck[i] && !sck_prev[i]) begin
               mosi_sr[i] = {mosi_sr[i][30:0], flash_mosi[i]};
               rises[i]++;
               if (rises[i] == 8) begin
                  seen_opc[i] = mosi_sr[i][7:0];
                  checkOutput("mosi_opcode", seen_opc[i], sess_cmd[i]);
               end
               if (rises[i] > 8) checkOutput("mosi_zero", flash_mosi[i], 1'b0);
               if (rises[i] == 32 && seen_opc[i] == READ_OP) seen_addr[i] = mosi_sr[i][23:0];
            end
            sck_prev[i] = flash_sck[i];
            flash_miso[i] = 1'b0;
            if (!flash_cs_n[i] && rises[i] >= 8) begin
               hdr = (seen_opc[i] == READ_OP) ? 32 : 8;
               if (rises[i] >= hdr) begin
                  j   = (rises[i] - hdr) / 8;
                  b   = (rises[i] - hdr) % 8;
                  byt = ref_byte(seen_opc[i], seen_addr[i], j);
                  flash_miso[i] = byt[7 - b];
               end
            end

            // host side: session, handshake and data rules
            checkOutput("cs_n", flash_cs_n[i], !sess_new);
            if (!sess_new) begin
               checkOutput("idle_busy", busy[i], 1'b0);
               checkOutput("idle_sck", flash_sck[i], 1'b0);
               checkOutput("idle_mosi", flash_mosi[i], 1'b0);
            end else if (!prev_busy[i]) begin
               checkOutput("busy_rise", busy[i], exp_rise);
            end
            if (data_out[i] !== prev_data[i]) begin
               allowed = (start && data_out[i] == 8'hFF) || (sess_new && prev_busy[i] && !busy[i]);
               checkOutput("data_change_allowed", allowed, 1'b1);
            end
            if (sess_new && !start && prev_busy[i] && !busy[i]) begin
               hdr = (sess_cmd[i] == READ_OP) ? 32 : 8;
               checkOutput("byte_value", data_out[i], ref_byte(sess_cmd[i], 24'h0, delivered[i]));
               checkOutput("byte_rises", rises[i], hdr + 8 * (delivered[i] + 1));
               fall_rises[i] = rises[i];
               delivered[i]++;
            end

            prev_busy[i] = busy[i];
            prev_data[i] = data_out[i];
            en_prev[i]   = en_last[i];
            en_last[i]   = enable[i];
            cr_last[i]   = continue_read[i];
            cmd_last[i]  = cmd_in;
            sess[i]      = sess_new;
         end
      end
   end

   task automatic applyStimulus(input int i, input logic en, input logic cr, input logic [7:0] c);
      @(posedge clk_in); #2;
      enable[i] = en; continue_read[i] = cr; cmd_in = c;
   endtask

   task automatic pulseContinue(input int i);
      @(posedge clk_in); #2; continue_read[i] = 1'b1;
      @(posedge clk_in); #2; continue_read[i] = 1'b0;
   endtask

   task automatic endSession(input int i);
      applyStimulus(i, 1'b0, 1'b0, cmd_in);
      repeat (3) @(posedge clk_in);
   endtask

   task automatic waitByte(input int i);
      int n;
      n = 0;
      repeat (2) @(negedge clk_in);
      while (busy[i] && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      #1;
      if (busy[i]) checkOutput("busy_timeout", busy[i], 1'b0);
   endtask

   task automatic waitRises(input int i, input int target);
      int n;
      n = 0;
      @(negedge clk_in); #1;
      while (rises[i] < target && n < 1000) begin
         @(negedge clk_in); #1;
         n++;
      end
      if (rises[i] < target) checkOutput("rises_timeout", rises[i], target);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         i, nbytes;
      logic [7:0] opc;
      reset_in = 1'b1;
      cmd_in   = 8'h00;
      for (int k = 0; k < NDUT; k++) begin
         enable[k] = 1'b0; continue_read[k] = 1'b0;
      end
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      repeat (3) @(posedge clk_in);
      #2 reset_in = 1'b0;

      @(negedge clk_in); #1;
      for (int k = 0; k < NDUT; k++) begin
         checkOutput("reset_data_out", data_out[k], 8'hFF);
         checkOutput("reset_busy", busy[k], 1'b0);
         checkOutput("reset_cs_n", flash_cs_n[k], 1'b1);
         checkOutput("reset_sck", flash_sck[k], 1'b0);
      end
      repeat (10) @(posedge clk_in);

      $display("[TB] READ session on every CLK_DIV instance");
      for (int k = 0; k < NDUT; k++) begin
         applyStimulus(k, 1'b1, 1'b0, READ_OP);
         pulseContinue(k);
         waitByte(k);
         checkOutput("read_byte0", data_out[k], 8'hA5);
         checkOutput("read_rises0", fall_rises[k], 40);
         repeat (4) @(posedge clk_in);
         pulseContinue(k);
         @(negedge clk_in); #1;
         checkOutput("read_busy_poll", busy[k], 1'b1);
         waitByte(k);
         checkOutput("read_byte1", data_out[k], 8'h3C);
         checkOutput("read_rises1", fall_rises[k], 48);
         endSession(k);
      end

      $display("[TB] JEDEC ID session and ignored continue_read while busy");
      applyStimulus(0, 1'b1, 1'b0, 8'h9F);
      waitByte(0);
      checkOutput("jedec_byte0", data_out[0], 8'hEF);
      checkOutput("jedec_rises0", fall_rises[0], 16);
      pulseContinue(0);
      pulseContinue(0);
      waitByte(0);
      repeat (6) @(posedge clk_in);
      #1 checkOutput("jedec_delivered", delivered[0], 2);
      checkOutput("jedec_byte1", data_out[0], 8'h40);
      endSession(0);

      $display("[TB] abort during address phase, then restart");
      applyStimulus(0, 1'b1, 1'b0, READ_OP);
      waitRises(0, 12);
      applyStimulus(0, 1'b0, 1'b0, READ_OP);
      @(negedge clk_in);
      @(negedge clk_in); #1;
      checkOutput("abort_cs_n", flash_cs_n[0], 1'b1);
      checkOutput("abort_busy", busy[0], 1'b0);
      checkOutput("abort_sck", flash_sck[0], 1'b0);
      applyStimulus(0, 1'b1, 1'b0, READ_OP);
      waitByte(0);
      checkOutput("restart_byte0", data_out[0], 8'hA5);
      endSession(0);

      $display("[TB] randomized sessions");
      for (int r = 0; r < 8; r++) begin
         i      = $urandom_range(0, NDUT - 1);
         opc    = ($urandom_range(0, 1) == 1) ? READ_OP : 8'($urandom);
         nbytes = $urandom_range(1, 4);
         applyStimulus(i, 1'b1, 1'b0, opc);
         for (int n = 0; n < nbytes; n++) begin
            if (n > 0) begin
               repeat ($urandom_range(0, 3)) @(posedge clk_in);
               pulseContinue(i);
               if ($urandom_range(0, 1) == 1) pulseContinue(i);
            end
            waitByte(i);
         end
         checkOutput("rand_delivered", delivered[i], nbytes);
         endSession(i);
      end

      $display("[TB] asynchronous reset mid-transfer");
      applyStimulus(0, 1'b1, 1'b0, 8'h9F);
      waitRises(0, 11);
      @(negedge clk_in); #1;
      reset_in  = 1'b1;
      enable[0] = 1'b0;
      #1;
      checkOutput("areset_data_out", data_out[0], 8'hFF);
      checkOutput("areset_busy", busy[0], 1'b0);
      checkOutput("areset_cs_n", flash_cs_n[0], 1'b1);
      checkOutput("areset_sck", flash_sck[0], 1'b0);
      checkOutput("areset_mosi", flash_mosi[0], 1'b0);
      repeat (2) @(posedge clk_in);
      #2 reset_in = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, READ_OP);
      waitByte(0);
      checkOutput("post_reset_byte0", data_out[0], 8'hA5);
      endSession(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
